// File: rtl/seq_alu.sv
// seq_alu: sequential ALU, single-cycle ops plus an iterative Booth multiplier.
// Define SEQ_ALU_DIV_EN to build the restoring divider (DIV/FIX states); otherwise op 3 is illegal.
module seq_alu #(
  parameter int BITS    = 32,
  parameter int SH_BITS = 5
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [BITS-1:0] X,
  input  logic [BITS-1:0] Y,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] result_hi,
  output logic [BITS-1:0] result_lo,
  output logic            div_by_zero,
  output logic            illegal_op
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  localparam logic [3:0]         OP_MUL = 4'd2;
  localparam logic [3:0]         OP_DIV = 4'd3;
  localparam logic [SH_BITS-1:0] LAST   = SH_BITS'(BITS - 1);

  function automatic logic [BITS-1:0] f_single(input logic [3:0] f_op,
                                               input logic [BITS-1:0] a,
                                               input logic [BITS-1:0] b);
    logic [2*BITS-1:0]  dbl;
    logic [SH_BITS-1:0] amt;
    amt = b[SH_BITS-1:0];
    dbl = {a, a};
    case (f_op)
      4'd0:    f_single = a + b;
      4'd1:    f_single = a - b;
      4'd4:    f_single = a >> amt;
      4'd5:    f_single = a << amt;
      4'd6:    begin dbl = dbl >> amt; f_single = dbl[BITS-1:0]; end
      4'd7:    begin dbl = dbl << amt; f_single = dbl[2*BITS-1:BITS]; end
      4'd8:    f_single = a & b;
      4'd9:    f_single = a | b;
      4'd10:   f_single = '0 - a;
      4'd11:   f_single = ~a;
      4'd12:   f_single = b + BITS'(4);
      default: f_single = '0;
    endcase
  endfunction

  state_t                 r_state, w_next;
  logic                   r_req, w_accept, w_load, w_illegal, w_mul_step, w_step;
  logic [3:0]             r_op;
  logic signed [BITS-1:0] r_x, r_y;
  logic [SH_BITS-1:0]     r_cnt;
  logic signed [BITS:0]   r_acc, w_mc, w_sum, w_acc_n;
  logic [BITS-1:0]        r_mq, w_mq_n;
  logic                   r_qm1;
  logic [BITS-1:0]        r_hi, r_lo, w_res_hi, w_res_lo;
  logic                   r_dbz, r_ill, w_res_dbz, w_res_ill;

  // A request is registered for one cycle before the FSM leaves IDLE, so every op
  // pays one edge of decode; busy covers that cycle so no second request slips in.
  assign w_accept = clr_n && start && (r_state == IDLE) && !r_req;
  assign busy     = (r_state != IDLE) || r_req;
  assign done     = (r_state == DONE);
  assign w_load   = (w_next == DONE) && (r_state != DONE);

`ifdef SEQ_ALU_DIV_EN
  logic                   w_div_step, w_ge, r_sx, r_sy;
  logic [BITS-1:0]        r_rem, r_quo, r_dmag, w_rem_n, w_quo_n;
  logic [BITS:0]          w_shift;

  function automatic logic [BITS-1:0] f_mag(input logic signed [BITS-1:0] v);
    f_mag = v[BITS-1] ? -v : v;
  endfunction

  assign w_illegal = (r_op >= 4'd13);
  assign w_step    = w_mul_step || w_div_step;
  assign w_shift   = {r_rem, r_quo[BITS-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dmag});
  assign w_rem_n   = w_ge ? BITS'(w_shift - {1'b0, r_dmag}) : w_shift[BITS-1:0];
  assign w_quo_n   = {r_quo[BITS-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_quo  <= f_mag(X);
      r_dmag <= f_mag(Y);
      r_rem  <= '0;
      r_sx   <= X[BITS-1];
      r_sy   <= Y[BITS-1];
    end else if (w_div_step) begin
      r_rem  <= w_rem_n;
      r_quo  <= w_quo_n;
    end
  end
`else
  assign w_illegal = (r_op >= 4'd13) || (r_op == OP_DIV);
  assign w_step    = w_mul_step;
`endif

  always_comb begin
    w_next     = r_state;
    w_mul_step = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    w_div_step = 1'b0;
`endif
    case (r_state)
      IDLE: if (r_req) begin
        if (r_op == OP_MUL) begin
          w_next     = MUL;
          w_mul_step = 1'b1;
        end
`ifdef SEQ_ALU_DIV_EN
        else if ((r_op == OP_DIV) && (r_y != '0)) begin
          w_next     = DIV;
          w_div_step = 1'b1;
        end
`endif
        else w_next = DONE;
      end
      MUL: begin
        w_mul_step = 1'b1;
        if (r_cnt == LAST) w_next = DONE;
      end
`ifdef SEQ_ALU_DIV_EN
      DIV: begin
        w_div_step = 1'b1;
        if (r_cnt == LAST) w_next = FIX;
      end
      FIX:     w_next = DONE;
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Radix-2 Booth step; accumulator is one bit wider so -X of the most negative X fits.
  assign w_mc = {r_x[BITS-1], r_x};
  always_comb begin
    case ({r_mq[0], r_qm1})
      2'b01:   w_sum = r_acc + w_mc;
      2'b10:   w_sum = r_acc - w_mc;
      default: w_sum = r_acc;
    endcase
  end
  assign w_acc_n = {w_sum[BITS], w_sum[BITS:1]};
  assign w_mq_n  = {w_sum[0], r_mq[BITS-1:1]};

  always_comb begin
    w_res_lo  = f_single(r_op, r_x, r_y);
    w_res_hi  = {BITS{w_res_lo[BITS-1]}};
    w_res_dbz = 1'b0;
    w_res_ill = w_illegal;
    if (r_state == MUL) begin
      w_res_hi  = w_acc_n[BITS-1:0];
      w_res_lo  = w_mq_n;
      w_res_ill = 1'b0;
    end
`ifdef SEQ_ALU_DIV_EN
    else if (r_state == FIX) begin
      w_res_hi  = r_sx ? -r_rem : r_rem;
      w_res_lo  = (r_sx ^ r_sy) ? -r_quo : r_quo;
      w_res_ill = 1'b0;
    end else if (r_op == OP_DIV) begin
      w_res_hi  = r_x;
      w_res_lo  = '1;
      w_res_dbz = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= w_accept;
      if (w_accept)    r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + 1'b1;
      if (w_load) begin
        r_hi  <= w_res_hi;
        r_lo  <= w_res_lo;
        r_dbz <= w_res_dbz;
        r_ill <= w_res_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op  <= op;
      r_x   <= X;
      r_y   <= Y;
      r_acc <= '0;
      r_mq  <= Y;
      r_qm1 <= 1'b0;
    end else if (w_mul_step) begin
      r_acc <= w_acc_n;
      r_mq  <= w_mq_n;
      r_qm1 <= r_mq[0];
    end
  end

  assign result_hi   = r_hi;
  assign result_lo   = r_lo;
  assign div_by_zero = r_dbz;
  assign illegal_op  = r_ill;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random ops against an arithmetic reference model.
module tb_seq_alu;
  localparam int BITS = 32;

  logic            clk, clr_n, start;
  logic [3:0]      op;
  logic [BITS-1:0] X, Y;
  logic            busy, done, div_by_zero, illegal_op;
  logic [BITS-1:0] result_hi, result_lo;
  int              n_total, n_bad;

  seq_alu #(.BITS(BITS), .SH_BITS(5)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .X(X), .Y(Y),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on wide signed integers, rotations one bit at a time.
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dbz, output logic ill, output int lat);
    longint sx, sy, p;
    int     amt;
    bit     wide;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    amt = int'(y[4:0]);
    hi = '0; lo = '0; dbz = 1'b0; ill = 1'b0; lat = 1; wide = 1'b0;
    case (o)
      4'd0:  lo = x + y;
      4'd1:  lo = x - y;
      4'd2:  begin p = sx * sy; {hi, lo} = p; lat = 32; wide = 1'b1; end
`ifdef SEQ_ALU_DIV_EN
      4'd3: begin
        wide = 1'b1;
        if (y == 0) begin lo = 32'hFFFF_FFFF; hi = x; dbz = 1'b1; end
        else begin lo = 32'(sx / sy); hi = 32'(sx % sy); lat = 33; end
      end
`endif
      4'd4:  lo = x >> amt;
      4'd5:  lo = x << amt;
      4'd6:  begin lo = x; repeat (amt) lo = {lo[0], lo[31:1]}; end
      4'd7:  begin lo = x; repeat (amt) lo = {lo[30:0], lo[31]}; end
      4'd8:  lo = x & y;
      4'd9:  lo = x | y;
      4'd10: lo = 32'd0 - x;
      4'd11: lo = ~x;
      4'd12: lo = y + 32'd4;
      default: ill = 1'b1;
    endcase
    if (!wide) hi = {32{lo[31]}};
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] e_hi, e_lo;
    logic        e_dbz, e_ill;
    int          e_lat, lat;
    bit          got;
    model(o, x, y, e_hi, e_lo, e_dbz, e_ill, e_lat);
    @(negedge clk);
    op = o; X = x; Y = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); X = $urandom(); Y = $urandom();
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) got = 1'b1;
      else if (e_lat > 4 && lat == 3) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    chk($sformatf("done_seen op%0d", o), 64'(got), 64'd1);
    chk($sformatf("latency op%0d", o), 64'(lat), 64'(e_lat));
    chk($sformatf("lo op%0d x=%h y=%h", o, x, y), 64'(result_lo), 64'(e_lo));
    chk($sformatf("hi op%0d x=%h y=%h", o, x, y), 64'(result_hi), 64'(e_hi));
    chk($sformatf("dbz op%0d", o), 64'(div_by_zero), 64'(e_dbz));
    chk($sformatf("ill op%0d", o), 64'(illegal_op), 64'(e_ill));
    chk($sformatf("busy_in_done op%0d", o), 64'(busy), 64'd1);
    start = 1'b1; op = 4'd0; X = 32'h1234; Y = 32'h1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("done_single_pulse op%0d", o), 64'(done), 64'd0);
    chk($sformatf("start_in_done_ignored op%0d", o), 64'(busy), 64'd0);
    chk($sformatf("hold_lo op%0d", o), 64'(result_lo), 64'(e_lo));
    chk($sformatf("hold_hi op%0d", o), 64'(result_hi), 64'(e_hi));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int pulses;
    n_total = 0; n_bad = 0;
    clr_n = 1'b0; start = 1'b1; op = 4'd0; X = 32'd5; Y = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1; start = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_ill", 64'(illegal_op), 64'd0);
    @(negedge clk);
    chk("start_during_reset_discarded", 64'(busy), 64'd0);

    run_op(4'd0,  32'h7FFF_FFFF, 32'h0000_0001);
    run_op(4'd5,  32'h0000_0001, 32'h0000_0023);
    run_op(4'd3,  32'hFFFF_FFF9, 32'h0000_0002);
    run_op(4'd3,  32'h0000_0005, 32'h0000_0000);
    run_op(4'd3,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd3,  32'h0000_0006, 32'h0000_0003);
    run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(4'd4,  32'h8000_0000, 32'h0000_001F);
    run_op(4'd4,  32'hDEAD_BEEF, 32'hFFFF_FFE0);
    run_op(4'd6,  32'h0000_0001, 32'h0000_0001);
    run_op(4'd7,  32'h8000_0001, 32'h0000_0004);
    run_op(4'd10, 32'h8000_0000, 32'h0);
    run_op(4'd12, 32'h0, 32'hFFFF_FFFE);
    run_op(4'd11, 32'h0F0F_0000, 32'h0);
    run_op(4'd2,  32'h8000_0000, 32'h8000_0000);
    run_op(4'd2,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'd2,  32'hFFFF_FFFD, 32'h0000_0007);

    @(negedge clk);
    op = 4'd2; X = $urandom(); Y = $urandom(); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(result_hi), 64'd0);
    chk("abort_lo", 64'(result_lo), 64'd0);
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_late_done", 64'(pulses), 64'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
